// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Instruction-memory bus between the fetch unit (master) and the memory
// (slave). The request is a level held until the memory acknowledges it.
//   imem_req    master->slave  fetch request, held until imem_ack
//   imem_addr   master->slave  fetch address
//   imem_ack    slave->master  response valid, qualifies imem_rdata
//   imem_rdata  slave->master  32-bit instruction word
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
   parameter int unsigned REG_WIDTH = 32
);
   logic                 imem_req;
   logic [REG_WIDTH-1:0] imem_addr;
   logic                 imem_ack;
   logic [31:0]          imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface : pc_fetch_unit_if

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Owns the architectural PC and runs a single-issue, non-pipelined fetch
// loop against instruction memory. At most one instruction is in flight.
// The branch/jump next-PC logic receives pc_out, inc_pc (PC+4) and the
// fetched instruction, and returns a redirect pair (pcsrc, new_pc) that is
// sampled only when the current instruction retires (valid and not stalled).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i_pcsrc        redirect taken, sampled at retire
//   i_new_pc       redirect target, sampled with i_pcsrc
//   i_stall        core not ready to consume the current instruction
//   imem           instruction-memory bus (master side)
//   o_instr_valid  o_instr / o_pc_out / o_inc_pc are valid
//   o_instr        latched instruction word
//   o_pc_out       PC of the current instruction
//   o_inc_pc       o_pc_out + 4, wrapping modulo 2^REG_WIDTH
//   o_fetch_err    one-cycle pulse when a request times out
//   o_misalign     sticky misaligned-redirect flag
//
// Build option: define PC_ALIGN_CHECK_EN to halt on a misaligned redirect
// (sets o_misalign, enters S_HALT until reset). Without it the low two bits
// of the redirect target are cleared and o_misalign is tied low.
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int unsigned          REG_WIDTH = 32,
   parameter logic [REG_WIDTH-1:0] RESET_PC  = '0,
   parameter int unsigned          TIMEOUT   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_pcsrc,
   input  logic [REG_WIDTH-1:0] i_new_pc,
   input  logic                 i_stall,
   pc_fetch_unit_if.master      imem,
   output logic                 o_instr_valid,
   output logic [31:0]          o_instr,
   output logic [REG_WIDTH-1:0] o_pc_out,
   output logic [REG_WIDTH-1:0] o_inc_pc,
   output logic                 o_fetch_err,
   output logic                 o_misalign
);

   localparam int unsigned      CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RESET,
      S_REQ,
      S_VALID,
      S_HALT
   } state_t;

   state_t               r_state,     w_state_nxt;
   logic [REG_WIDTH-1:0] r_pc,        w_pc_nxt;
   logic [31:0]          r_instr,     w_instr_nxt;
   logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
   // r_fetch_err doubles as the back-off marker: while it is high the
   // request is dropped for that one cycle before the same address is retried.
   logic                 r_fetch_err, w_fetch_err_nxt;
   logic                 w_req;
   logic [REG_WIDTH-1:0] w_inc_pc;
   logic [REG_WIDTH-1:0] w_redirect_pc;

`ifdef PC_ALIGN_CHECK_EN
   logic                 r_misalign,  w_misalign_nxt;
`endif

   assign w_inc_pc = r_pc + REG_WIDTH'(4);

`ifdef PC_ALIGN_CHECK_EN
   assign w_redirect_pc = i_new_pc;
`else
   // Word-align the target instead of trapping.
   assign w_redirect_pc = i_new_pc & ~REG_WIDTH'(3);
`endif

   // ------------------------------------------------------------------------
   // Next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no branch can infer a latch.
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_instr_nxt     = r_instr;
      w_cnt_nxt       = r_cnt;
      w_fetch_err_nxt = 1'b0;
      w_req           = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      w_misalign_nxt  = r_misalign;
`endif

      case (r_state)
         S_RESET: begin
            w_state_nxt = S_REQ;
         end

         S_REQ: begin
            // During the back-off cycle nothing is outstanding, so any ack is
            // ignored and the counter stays cleared.
            if (!r_fetch_err) begin
               w_req = 1'b1;
               // Ack is checked before the timeout so a late ack still wins.
               if (imem.imem_ack) begin
                  w_instr_nxt = imem.imem_rdata;
                  w_cnt_nxt   = '0;
                  w_state_nxt = S_VALID;
               end else if (r_cnt == CNT_LAST) begin
                  w_fetch_err_nxt = 1'b1;
                  w_cnt_nxt       = '0;
               end else begin
                  w_cnt_nxt = r_cnt + CNT_W'(1);
               end
            end
         end

         S_VALID: begin
            if (!i_stall) begin
               if (i_pcsrc) begin
`ifdef PC_ALIGN_CHECK_EN
                  if (i_new_pc[1:0] != 2'b00) begin
                     w_misalign_nxt = 1'b1;
                     w_state_nxt    = S_HALT;
                  end else begin
                     w_pc_nxt    = w_redirect_pc;
                     w_state_nxt = S_REQ;
                  end
`else
                  w_pc_nxt    = w_redirect_pc;
                  w_state_nxt = S_REQ;
`endif
               end else begin
                  w_pc_nxt    = w_inc_pc;
                  w_state_nxt = S_REQ;
               end
            end
         end

         S_HALT: begin
            // Only reset leaves this state.
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state     <= S_RESET;
         r_pc        <= RESET_PC;
         r_instr     <= '0;
         r_cnt       <= '0;
         r_fetch_err <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_instr     <= w_instr_nxt;
         r_cnt       <= w_cnt_nxt;
         r_fetch_err <= w_fetch_err_nxt;
`ifdef PC_ALIGN_CHECK_EN
         r_misalign  <= w_misalign_nxt;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign imem.imem_req  = w_req;
   assign imem.imem_addr = r_pc;

   assign o_instr_valid  = (r_state == S_VALID);
   assign o_instr        = r_instr;
   assign o_pc_out       = r_pc;
   assign o_inc_pc       = w_inc_pc;
   assign o_fetch_err    = r_fetch_err;

`ifdef PC_ALIGN_CHECK_EN
   assign o_misalign     = r_misalign;
`else
   assign o_misalign     = 1'b0;
`endif

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Drives pc_fetch_unit against a behavioural instruction memory that returns
// 32'h1111_0000 + addr. Each acknowledged fetch pushes the expected
// {pc, instr, inc_pc} to a queue; the entry is popped and compared when the
// unit presents the instruction as valid.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

   localparam int unsigned REG_WIDTH = 32;
   localparam int unsigned TIMEOUT   = 16;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] MEM_BASE  = 32'h1111_0000;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] inc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        pcsrc;
   logic [31:0] new_pc;
   logic        stall;
   logic        mem_en;
   logic        force_ack;

   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] pc_out;
   logic [31:0] inc_pc;
   logic        fetch_err;
   logic        misalign;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        sb_q[$];

   pc_fetch_unit_if #(.REG_WIDTH(REG_WIDTH)) bus ();

   // Zero-wait memory while enabled; force_ack injects a spurious ack.
   assign bus.imem_ack   = (bus.imem_req & mem_en) | force_ack;
   assign bus.imem_rdata = MEM_BASE + bus.imem_addr;

   pc_fetch_unit #(
      .REG_WIDTH (REG_WIDTH),
      .RESET_PC  (RESET_PC),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_pcsrc       (pcsrc),
      .i_new_pc      (new_pc),
      .i_stall       (stall),
      .imem          (bus.master),
      .o_instr_valid (instr_valid),
      .o_instr       (instr),
      .o_pc_out      (pc_out),
      .o_inc_pc      (inc_pc),
      .o_fetch_err   (fetch_err),
      .o_misalign    (misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got no finish, need finish)");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Holds reset for two cycles and checks the reset state on the way.
   task automatic reset_pulse();
      rst = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_valid",    instr_valid,   0);
         check("rst_req",      bus.imem_req,  0);
         check("rst_pc",       pc_out,        RESET_PC);
         check("rst_instr",    instr,         0);
         check("rst_fetch_err", fetch_err,    0);
         check("rst_misalign", misalign,      0);
      end
      rst = 1'b0;
   endtask

   // Entered at a negedge. Waits for the fetch of exp_addr, checks it,
   // consumes the instruction (optionally stalling with pcsrc toggling) and
   // retires it with the given redirect. Returns at the following negedge.
   task automatic run_instr(input logic [31:0] exp_addr, input bit strict,
                            input int n_stall, input bit redir, input logic [31:0] tgt);
      int   waited = 0;
      exp_t e;
      while (!(bus.imem_req && bus.imem_ack) && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!(bus.imem_req && bus.imem_ack)) begin
         check("ack_seen", bus.imem_req & bus.imem_ack, 1);
         return;
      end
      if (strict) begin
         check("zero_wait_cycles", waited, 0);
         check("valid_gap", instr_valid, 0);
      end
      check("fetch_addr", bus.imem_addr, exp_addr);
      e.pc    = exp_addr;
      e.instr = MEM_BASE + exp_addr;
      e.inc   = exp_addr + 32'd4;
      sb_q.push_back(e);

      @(negedge clk);
      check("valid_latency", instr_valid, 1);
      check("valid_no_req",  bus.imem_req, 0);
      if (sb_q.size() == 0) begin
         check("sb_nonempty", sb_q.size(), 1);
         return;
      end
      e = sb_q.pop_front();
      check("instr",  instr,  e.instr);
      check("pc_out", pc_out, e.pc);
      check("inc_pc", inc_pc, e.inc);

      for (int k = 0; k < n_stall; k++) begin
         stall  = 1'b1;
         pcsrc  = k[0];
         new_pc = 32'h0000_0080;
         @(negedge clk);
         check("stall_valid",  instr_valid,  1);
         check("stall_no_req", bus.imem_req, 0);
         check("stall_instr",  instr,        e.instr);
         check("stall_pc",     pc_out,       e.pc);
      end

      stall  = 1'b0;
      pcsrc  = redir;
      new_pc = tgt;
      @(negedge clk);
      pcsrc  = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      pcsrc     = 1'b0;
      new_pc    = '0;
      stall     = 1'b0;
      mem_en    = 1'b1;
      force_ack = 1'b0;

      // Reset, then sequential fetch at 2 cycles/instruction.
      reset_pulse();
      run_instr(32'h0, 1'b0, 0, 1'b0, 32'h0);
      for (int a = 4; a <= 12; a += 4)
         run_instr(32'(a), 1'b1, 0, 1'b0, 32'h0);

      // Redirect at 0x10 to 0x40; valid must drop for exactly one cycle.
      run_instr(32'h10, 1'b1, 0, 1'b1, 32'h40);
      // Stall five cycles with pcsrc toggling; pcsrc must be ignored.
      run_instr(32'h40, 1'b1, 5, 1'b0, 32'h0);
      // Jump to the top of the address space to exercise inc_pc wrap.
      run_instr(32'h44, 1'b1, 0, 1'b1, 32'hFFFF_FFFC);
      run_instr(32'hFFFF_FFFC, 1'b1, 0, 1'b0, 32'h0);
      // Redirect to own pc (tight loop refetch).
      run_instr(32'h0, 1'b1, 0, 1'b1, 32'h0);
      run_instr(32'h0, 1'b1, 0, 1'b0, 32'h0);
      run_instr(32'h4, 1'b1, 0, 1'b0, 32'h0);

      // Silent memory at 0x8: fetch_err every TIMEOUT+1 cycles, same address.
      mem_en = 1'b0;
      for (int i = 0; i < 66; i++) begin
         if (i != 0) @(negedge clk);
         check("to_fetch_err", fetch_err,    (i % 17) == 16);
         check("to_req",       bus.imem_req, (i % 17) != 16);
         check("to_addr",      bus.imem_addr, 32'h8);
      end
      // Ack arrives in the cycle the counter is at TIMEOUT-1: ack wins.
      @(negedge clk);
      check("late_ack_req", bus.imem_req, 1);
      mem_en = 1'b1;
      @(negedge clk);
      check("late_ack_valid",     instr_valid, 1);
      check("late_ack_no_err",    fetch_err,   0);
      check("late_ack_instr",     instr,       MEM_BASE + 32'h8);

      // Misaligned redirect to 0x42.
      stall  = 1'b0;
      pcsrc  = 1'b1;
      new_pc = 32'h0000_0042;
      @(negedge clk);
      pcsrc  = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      repeat (4) begin
         check("halt_misalign", misalign,     1);
         check("halt_no_req",   bus.imem_req, 0);
         check("halt_pc",       pc_out,       32'h8);
         @(negedge clk);
      end
`else
      check("no_misalign", misalign, 0);
      run_instr(32'h40, 1'b1, 0, 1'b0, 32'h0);
`endif

      // Reset clears everything, including a sticky misalign.
      reset_pulse();
      run_instr(32'h0, 1'b0, 0, 1'b0, 32'h0);

      // Reset while a fetch of 0x4 is outstanding and ack is asserted.
      mem_en = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_req", bus.imem_req, 1);
      rst       = 1'b1;
      force_ack = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("rst_ack_valid", instr_valid, 0);
         check("rst_ack_pc",    pc_out,      RESET_PC);
         check("rst_ack_instr", instr,       0);
      end
      rst       = 1'b0;
      force_ack = 1'b0;
      mem_en    = 1'b1;
      @(negedge clk);
      run_instr(RESET_PC, 1'b1, 0, 1'b0, 32'h0);
      run_instr(RESET_PC + 32'd4, 1'b1, 0, 1'b0, 32'h0);

      check("sb_drained", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pc_fetch_unit
